// File: rtl/cpu_fetch_stage.sv
`default_nettype none
// ============================================================================
// cpu_fetch_stage : tetris CPU fetch stage (PC, imem, live figure, out slice)
// Optional CPU_FETCH_PERF_EN adds perf_fetched / perf_stalled.  Rev 1.0
// ============================================================================
module cpu_fetch_stage #(
   parameter int WIDTH         = 8,
   parameter int MEM_WIDTH     = 4,
   parameter int BLOCKS        = 4,
   parameter int INSTR_NUMBERS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         imem_we,
   input  logic [WIDTH-1:0]             imem_waddr,
   input  logic [2*WIDTH-1:0]           imem_wdata,
   input  logic                         jump_en,
   input  logic [WIDTH-1:0]             jump_addr,
   input  logic                         wb_en,
   input  logic [WIDTH*BLOCKS-1:0]      wb_coord_x,
   input  logic [WIDTH*BLOCKS-1:0]      wb_coord_y,
   input  logic [WIDTH*MEM_WIDTH-1:0]   wb_bus,
   input  logic                         touch,
   input  logic [WIDTH*BLOCKS-1:0]      spawn_x,
   input  logic [WIDTH*BLOCKS-1:0]      spawn_y,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [2*WIDTH-1:0]           instr,
   output logic [WIDTH-1:0]             instr_addr,
   output logic [WIDTH*BLOCKS-1:0]      coord_x,
   output logic [WIDTH*BLOCKS-1:0]      coord_y,
   output logic [WIDTH*MEM_WIDTH-1:0]   bus
`ifdef CPU_FETCH_PERF_EN
   ,
   output logic [31:0]                  perf_fetched,
   output logic [31:0]                  perf_stalled
`endif
);

   localparam int               c_AW    = (INSTR_NUMBERS > 1) ? $clog2(INSTR_NUMBERS) : 1;
   localparam logic [WIDTH:0]   c_DEPTH = (WIDTH+1)'(INSTR_NUMBERS);
   localparam logic [WIDTH-1:0] c_LAST  = WIDTH'(INSTR_NUMBERS - 1);

   logic [2*WIDTH-1:0]         r_imem [0:INSTR_NUMBERS-1];
   logic [WIDTH-1:0]           r_pc;
   logic                       r_valid;
   logic [2*WIDTH-1:0]         r_instr;
   logic [WIDTH-1:0]           r_addr;
   logic [WIDTH*BLOCKS-1:0]    r_cx;
   logic [WIDTH*BLOCKS-1:0]    r_cy;
   logic [WIDTH*MEM_WIDTH-1:0] r_bus;

   logic                       w_adv;
   logic                       w_jump_in_range;
   logic                       w_waddr_in_range;
   logic [WIDTH-1:0]           w_pc_next;
   logic [2*WIDTH-1:0]         w_rdata;

   assign w_adv            = !r_valid || out_ready;
   assign w_jump_in_range  = ({1'b0, jump_addr} < c_DEPTH);
   assign w_waddr_in_range = ({1'b0, imem_waddr} < c_DEPTH);
   assign w_pc_next        = (r_pc == c_LAST) ? '0 : r_pc + 1'b1;
   // Asynchronous array read sampled by the slice gives read-before-write on collision.
   assign w_rdata          = r_imem[r_pc[c_AW-1:0]];

   always_ff @(posedge clk) begin
      if (imem_we && w_waddr_in_range) begin
         r_imem[imem_waddr[c_AW-1:0]] <= imem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= '0;
         r_valid <= 1'b0;
         r_instr <= '0;
         r_addr  <= '0;
      end else if (jump_en) begin
         r_pc    <= w_jump_in_range ? jump_addr : '0;
         r_valid <= 1'b0;
      end else if (w_adv) begin
         r_instr <= w_rdata;
         r_addr  <= r_pc;
         r_valid <= 1'b1;
         r_pc    <= w_pc_next;
      end
   end

   // Figure state runs independently of fetch stalls; touch owns coords, wb still owns bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cx  <= '0;
         r_cy  <= '0;
         r_bus <= '0;
      end else begin
         if (touch) begin
            r_cx <= spawn_x;
            r_cy <= spawn_y;
         end else if (wb_en) begin
            r_cx <= wb_coord_x;
            r_cy <= wb_coord_y;
         end
         if (wb_en) begin
            r_bus <= wb_bus;
         end
      end
   end

`ifdef CPU_FETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_stalled;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_fetched <= '0;
         r_perf_stalled <= '0;
      end else begin
         if (r_valid && out_ready) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
         end
         if (r_valid && !out_ready) begin
            r_perf_stalled <= r_perf_stalled + 32'd1;
         end
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_stalled = r_perf_stalled;
`endif

   assign out_valid  = r_valid;
   assign instr      = r_instr;
   assign instr_addr = r_addr;
   assign coord_x    = r_cx;
   assign coord_y    = r_cy;
   assign bus        = r_bus;

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_cpu_fetch_stage : scoreboard bench with a queue-based reference model
// ============================================================================
module tb_cpu_fetch_stage;

   localparam int W = 8, MW = 4, BL = 4, DEPTH = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            imem_we;
   logic [W-1:0]    imem_waddr;
   logic [2*W-1:0]  imem_wdata;
   logic            jump_en;
   logic [W-1:0]    jump_addr;
   logic            wb_en;
   logic [W*BL-1:0] wb_coord_x, wb_coord_y;
   logic [W*MW-1:0] wb_bus;
   logic            touch;
   logic [W*BL-1:0] spawn_x, spawn_y;
   logic            out_ready;
   logic            out_valid;
   logic [2*W-1:0]  instr;
   logic [W-1:0]    instr_addr;
   logic [W*BL-1:0] coord_x, coord_y;
   logic [W*MW-1:0] bus;
`ifdef CPU_FETCH_PERF_EN
   logic [31:0]     perf_fetched, perf_stalled;
`endif

   always #5 clk = ~clk;

   cpu_fetch_stage #(.WIDTH(W), .MEM_WIDTH(MW), .BLOCKS(BL), .INSTR_NUMBERS(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .jump_en(jump_en), .jump_addr(jump_addr),
      .wb_en(wb_en), .wb_coord_x(wb_coord_x), .wb_coord_y(wb_coord_y), .wb_bus(wb_bus),
      .touch(touch), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .out_ready(out_ready), .out_valid(out_valid),
      .instr(instr), .instr_addr(instr_addr),
      .coord_x(coord_x), .coord_y(coord_y), .bus(bus)
`ifdef CPU_FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_stalled(perf_stalled)
`endif
   );

   typedef struct {
      logic [2*W-1:0] i;
      logic [W-1:0]   a;
   } fetch_t;

   fetch_t          sb_q[$];
   logic [2*W-1:0]  m_mem [DEPTH];
   int              m_pc;
   bit              m_valid;
   logic [2*W-1:0]  m_instr;
   logic [W-1:0]    m_addr;
   logic [W*BL-1:0] m_cx, m_cy;
   logic [W*MW-1:0] m_bus;
   logic [31:0]     m_fetched, m_stalled;
   int              n_cmp = 0;
   int              n_err = 0;
   bit              mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one call per rising edge, using the inputs applied for that edge.
   task automatic model_step();
      bit             acc;
      logic [2*W-1:0] rd;
      fetch_t         f;
      acc = m_valid && out_ready;
      rd  = m_mem[m_pc];
      if (rst) begin
         m_fetched = 0;
         m_stalled = 0;
      end else begin
         if (acc) m_fetched++;
         if (m_valid && !out_ready) m_stalled++;
      end
      if (rst || jump_en) begin
         if (m_valid && !acc && sb_q.size() > 0) void'(sb_q.pop_back());
         m_valid = 1'b0;
         if (rst) begin
            m_pc = 0; m_instr = '0; m_addr = '0;
         end else begin
            m_pc = (int'(jump_addr) < DEPTH) ? int'(jump_addr) : 0;
         end
      end else if (!m_valid || out_ready) begin
         f.i = rd;
         f.a = W'(m_pc);
         sb_q.push_back(f);
         m_instr = rd; m_addr = W'(m_pc); m_valid = 1'b1;
         m_pc = (m_pc + 1) % DEPTH;
      end
      if (imem_we && int'(imem_waddr) < DEPTH) m_mem[int'(imem_waddr)] = imem_wdata;
      if (rst) begin
         m_cx = '0; m_cy = '0; m_bus = '0;
      end else begin
         if (touch) begin
            m_cx = spawn_x; m_cy = spawn_y;
         end else if (wb_en) begin
            m_cx = wb_coord_x; m_cy = wb_coord_y;
         end
         if (wb_en) m_bus = wb_bus;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT hands over a fetch.
   always @(negedge clk) begin
      if (mon_en) begin
         fetch_t e;
         check("out_valid", 64'(out_valid), 64'(m_valid));
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected", 64'(out_valid), 64'd0);
            end else begin
               e = sb_q.pop_front();
               check("instr", 64'(instr), 64'(e.i));
               check("instr_addr", 64'(instr_addr), 64'(e.a));
            end
         end
         check("coord_x", 64'(coord_x), 64'(m_cx));
         check("coord_y", 64'(coord_y), 64'(m_cy));
         check("bus", 64'(bus), 64'(m_bus));
`ifdef CPU_FETCH_PERF_EN
         check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
         check("perf_stalled", 64'(perf_stalled), 64'(m_stalled));
`endif
      end
   end

   task automatic idle_inputs();
      imem_we = 0; imem_waddr = '0; imem_wdata = '0;
      jump_en = 0; jump_addr = '0; wb_en = 0; touch = 0;
      wb_coord_x = '0; wb_coord_y = '0; wb_bus = '0; spawn_x = '0; spawn_y = '0;
   endtask

   initial begin
      logic [2*W-1:0] prog [DEPTH];
      int             guard;
      m_pc = 0; m_valid = 0; m_instr = '0; m_addr = '0;
      m_cx = '0; m_cy = '0; m_bus = '0; m_fetched = 0; m_stalled = 0;
      prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333;
      prog[3] = 16'h4444; prog[4] = 16'h5555;
      idle_inputs();
      rst = 1; out_ready = 1;
      tick();
      mon_en = 1;
      for (int i = 0; i < DEPTH; i++) begin
         imem_we = 1; imem_waddr = W'(i); imem_wdata = prog[i];
         tick();
      end
      // Out-of-range write must not alias onto a real entry.
      imem_waddr = 8'd5; imem_wdata = 16'hDEAD;
      tick();
      imem_we = 0;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_instr", 64'(instr), 64'd0);
      check("rst_addr", 64'(instr_addr), 64'd0);
      check("rst_coord_x", 64'(coord_x), 64'd0);

      // Streaming fetch with wrap: 0,1,2,3,4,0,1,...
      rst = 0;
      for (int i = 0; i < 12; i++) tick();

      // Stall at address 2.
      guard = 0;
      while (!(m_valid && m_addr == 8'd2) && guard < 20) begin
         tick(); guard++;
      end
      check("reach_addr2", 64'(instr_addr), 64'd2);
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_addr", 64'(instr_addr), 64'd2);
         check("stall_instr", 64'(instr), 64'h3333);
      end
      out_ready = 1;
      tick(); tick();

      // Jump while stalled flushes the slice.
      out_ready = 0; tick();
      jump_en = 1; jump_addr = 8'd1;
      tick();
      check("jump_flush", 64'(out_valid), 64'd0);
      jump_en = 0; out_ready = 1;
      tick();
      check("jump_target", 64'(instr_addr), 64'd1);
      jump_en = 1; jump_addr = 8'd9;
      tick();
      jump_en = 0;
      tick();
      check("jump_oor", 64'(instr_addr), 64'd0);

      // touch and wb_en together.
      touch = 1; wb_en = 1;
      spawn_x = 32'h04050607; spawn_y = 32'h01020304;
      wb_coord_x = 32'hAAAAAAAA; wb_coord_y = 32'hBBBBBBBB; wb_bus = 32'hFF;
      tick();
      touch = 0; wb_en = 0;
      check("touch_cx", 64'(coord_x), 64'h04050607);
      check("touch_bus", 64'(bus), 64'hFF);

      // Randomized traffic, including collisions and mid-run resets.
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         out_ready  = ($urandom_range(0, 9) < 7);
         jump_en    = ($urandom_range(0, 99) < 8);
         jump_addr  = W'($urandom_range(0, 9));
         imem_we    = ($urandom_range(0, 7) == 0);
         imem_waddr = ($urandom_range(0, 1) == 0) ? W'(m_pc) : W'($urandom_range(0, 7));
         imem_wdata = 16'($urandom);
         touch      = ($urandom_range(0, 19) == 0);
         wb_en      = ($urandom_range(0, 6) == 0);
         wb_coord_x = $urandom; wb_coord_y = $urandom; wb_bus = $urandom;
         spawn_x    = $urandom; spawn_y = $urandom;
         tick();
      end
      rst = 0; idle_inputs(); out_ready = 1;
      for (int i = 0; i < 4; i++) tick();
      @(posedge clk);
      mon_en = 0;
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
